// File: rtl/axis_gen_regs_pkg.sv
// Shared register map, bit positions and reset values for the AXI-stream
// generator control/status block.
package axis_gen_regs_pkg;

  // Word indices (byte offset / 4) of the mapped registers.
  localparam int unsigned IDX_CTRL      = 0;
  localparam int unsigned IDX_STATUS    = 1;
  localparam int unsigned IDX_PKT_LEN   = 2;
  localparam int unsigned IDX_GAP       = 3;
  localparam int unsigned IDX_SEED      = 4;
  localparam int unsigned IDX_PKT_COUNT = 5;
  localparam int unsigned IDX_ID        = 6;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int CTRL_CLR_BIT    = 2;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_OVF_BIT  = 1;

  localparam logic [15:0] PKT_LEN_RST     = 16'd64;
  localparam logic [15:0] GAP_RST         = 16'd0;
  localparam logic [31:0] SEED_RST        = 32'd0;
  localparam logic [31:0] CORE_ID_DEFAULT = 32'h4147_0100;

  function automatic logic [31:0] applyStrb(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  strb);
    logic [31:0] merged;
    merged = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[b*8 +: 8] = newVal[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axis_gen_regs_if.sv
// Register read/write request interface between the AXI-lite bridges
// (master) and the generator register file (slave).
interface axis_gen_regs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] reg_wr_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic [STRB_WIDTH-1:0] reg_wr_strb;
  logic                  reg_wr_en;
  logic                  reg_wr_wait;
  logic                  reg_wr_ack;
  logic [ADDR_WIDTH-1:0] reg_rd_addr;
  logic                  reg_rd_en;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic                  reg_rd_wait;
  logic                  reg_rd_ack;

  modport master (
    output reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
    input  reg_wr_wait, reg_wr_ack,
    output reg_rd_addr, reg_rd_en,
    input  reg_rd_data, reg_rd_wait, reg_rd_ack
  );

  modport slave (
    input  reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
    output reg_wr_wait, reg_wr_ack,
    input  reg_rd_addr, reg_rd_en,
    output reg_rd_data, reg_rd_wait, reg_rd_ack
  );
endinterface

// File: rtl/axis_gen_sat_cnt.sv
// 32-bit saturating event counter with a sticky overflow flag.
// A clear coinciding with an increment leaves the count at 1 so no event is lost.
module axis_gen_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        clr_i,
  input  logic        ovfClr_i,
  output logic [31:0] count_o,
  output logic        ovf_o
);

  logic [31:0] count_q;
  logic        ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (clr_i) begin
        count_q <= {31'd0, inc_i};
      end else if (inc_i) begin
        if (count_q == 32'hFFFF_FFFF) ovf_q <= 1'b1;
        else                          count_q <= count_q + 32'd1;
      end
      if (ovfClr_i) ovf_q <= 1'b0;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/axis_gen_regs.sv
// Control/status register file for the AXI-stream generator: decodes the
// register interface, drives generator configuration and counts sent packets.
module axis_gen_regs
  import axis_gen_regs_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [31:0] CORE_ID    = CORE_ID_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_gen_regs_if.slave       regBus,
  output logic                 cfg_enable_o,
  output logic                 cfg_start_o,
  output logic [15:0]          cfg_pkt_len_o,
  output logic [15:0]          cfg_pkt_gap_o,
  output logic [31:0]          cfg_seed_o,
  input  logic                 stat_busy_i,
  input  logic                 stat_pkt_done_i
);

  localparam int IW = ADDR_WIDTH - 2;

  logic                  enable_q, enable_d;
  logic                  start_q, start_d;
  logic [15:0]           pktLen_q, pktLen_d;
  logic [15:0]           gap_q, gap_d;
  logic [31:0]           seed_q, seed_d;
  logic [DATA_WIDTH-1:0] rdData_q;
  logic                  rdAck_q, wrAck_q;

  logic [IW-1:0]         rdIdx, wrIdx;
  logic                  rdCapture, wrCapture;
  logic [DATA_WIDTH-1:0] rdMux, wrData;
  logic [STRB_WIDTH-1:0] wrStrb;
  logic [31:0]           lenMerged, gapMerged;
  logic                  ctrlClr, readClr;
  logic [31:0]           pktCount;
  logic                  ovf;

  // A request is captured only when no ack is outstanding, so a request
  // still held during its ack cycle cannot be taken twice.
  assign rdCapture = regBus.reg_rd_en && !rdAck_q;
  assign wrCapture = regBus.reg_wr_en && !wrAck_q;
  assign rdIdx     = regBus.reg_rd_addr[ADDR_WIDTH-1:2];
  assign wrIdx     = regBus.reg_wr_addr[ADDR_WIDTH-1:2];
  assign wrData    = regBus.reg_wr_data;
  assign wrStrb    = regBus.reg_wr_strb;

  always_comb begin
    rdMux = '0;
    case (rdIdx)
      IW'(IDX_CTRL):      rdMux[CTRL_ENABLE_BIT] = enable_q;
      IW'(IDX_STATUS): begin
        rdMux[STATUS_BUSY_BIT] = stat_busy_i;
        rdMux[STATUS_OVF_BIT]  = ovf;
      end
      IW'(IDX_PKT_LEN):   rdMux[15:0] = pktLen_q;
      IW'(IDX_GAP):       rdMux[15:0] = gap_q;
      IW'(IDX_SEED):      rdMux       = seed_q;
      IW'(IDX_PKT_COUNT): rdMux       = pktCount;
      IW'(IDX_ID):        rdMux       = CORE_ID;
      default:            rdMux       = '0;
    endcase
  end

  always_comb begin
    enable_d  = enable_q;
    start_d   = 1'b0;
    pktLen_d  = pktLen_q;
    gap_d     = gap_q;
    seed_d    = seed_q;
    ctrlClr   = 1'b0;
    lenMerged = applyStrb({16'd0, pktLen_q}, wrData, wrStrb);
    gapMerged = applyStrb({16'd0, gap_q}, wrData, wrStrb);
    if (wrCapture) begin
      case (wrIdx)
        IW'(IDX_CTRL): begin
          if (wrStrb[0]) begin
            enable_d = wrData[CTRL_ENABLE_BIT];
            start_d  = wrData[CTRL_START_BIT] && wrData[CTRL_ENABLE_BIT];
            ctrlClr  = wrData[CTRL_CLR_BIT];
          end
        end
        // A zero-length packet is meaningless to the core, so clamp to one beat.
        IW'(IDX_PKT_LEN): pktLen_d = (lenMerged[15:0] == 16'd0) ? 16'd1 : lenMerged[15:0];
        IW'(IDX_GAP):     gap_d    = gapMerged[15:0];
        IW'(IDX_SEED):    seed_d   = applyStrb(seed_q, wrData, wrStrb);
        default: ;
      endcase
    end
  end

  assign readClr = rdCapture && (rdIdx == IW'(IDX_PKT_COUNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b0;
      start_q  <= 1'b0;
      pktLen_q <= PKT_LEN_RST;
      gap_q    <= GAP_RST;
      seed_q   <= SEED_RST;
      rdData_q <= '0;
      rdAck_q  <= 1'b0;
      wrAck_q  <= 1'b0;
    end else begin
      enable_q <= enable_d;
      start_q  <= start_d;
      pktLen_q <= pktLen_d;
      gap_q    <= gap_d;
      seed_q   <= seed_d;
      rdAck_q  <= rdCapture;
      wrAck_q  <= wrCapture;
      if (rdCapture) rdData_q <= rdMux;
    end
  end

  axis_gen_sat_cnt cntInst (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (stat_pkt_done_i),
    .clr_i    (readClr || ctrlClr),
    .ovfClr_i (ctrlClr),
    .count_o  (pktCount),
    .ovf_o    (ovf)
  );

  logic unusedOk;
  assign unusedOk = ^{regBus.reg_rd_addr[1:0], regBus.reg_wr_addr[1:0],
                      lenMerged[31:16], gapMerged[31:16]};

  assign regBus.reg_rd_data = rdData_q;
  assign regBus.reg_rd_ack  = rdAck_q;
  assign regBus.reg_rd_wait = 1'b0;
  assign regBus.reg_wr_ack  = wrAck_q;
  assign regBus.reg_wr_wait = 1'b0;

  assign cfg_enable_o  = enable_q;
  assign cfg_start_o   = start_q;
  assign cfg_pkt_len_o = pktLen_q;
  assign cfg_pkt_gap_o = gap_q;
  assign cfg_seed_o    = seed_q;

endmodule

// File: tb/tb_axis_gen_regs.sv
// Directed self-checking bench for the generator register file: handshake
// timing, register map, START/CLR side effects, packet counter and reset.
module tb_axis_gen_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfgEnable, cfgStart;
  logic [15:0] cfgPktLen, cfgPktGap;
  logic [31:0] cfgSeed;
  logic        statBusy = 1'b0;
  logic        statPktDone = 1'b0;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  logic startAtAck;
  logic [31:0] rdVal;

  axis_gen_regs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) regIf ();

  axis_gen_regs dut (
    .clk             (clk),
    .rst             (rst),
    .regBus          (regIf),
    .cfg_enable_o    (cfgEnable),
    .cfg_start_o     (cfgStart),
    .cfg_pkt_len_o   (cfgPktLen),
    .cfg_pkt_gap_o   (cfgPktGap),
    .cfg_seed_o      (cfgSeed),
    .stat_busy_i     (statBusy),
    .stat_pkt_done_i (statPktDone)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfgStart) startCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Request is held across the ack cycle's closing edge to show it is not re-captured.
  task automatic regWrite(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit pulse);
    int lat;
    lat = 0;
    @(negedge clk);
    regIf.reg_wr_addr = addr;
    regIf.reg_wr_data = data;
    regIf.reg_wr_strb = strb;
    regIf.reg_wr_en   = 1'b1;
    if (pulse) statPktDone = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      statPktDone = 1'b0;
      if (regIf.reg_wr_ack) begin
        lat = i;
        break;
      end
    end
    checkOutput("wr_latency", lat, 1);
    startAtAck = cfgStart;
    @(negedge clk);
    checkOutput("wr_ack_width", {31'd0, regIf.reg_wr_ack}, 0);
    regIf.reg_wr_en = 1'b0;
  endtask

  task automatic regRead(input logic [7:0] addr, input bit pulse, output logic [31:0] data);
    int lat;
    lat  = 0;
    data = 32'hDEAD_BEEF;
    @(negedge clk);
    regIf.reg_rd_addr = addr;
    regIf.reg_rd_en   = 1'b1;
    if (pulse) statPktDone = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      statPktDone = 1'b0;
      if (regIf.reg_rd_ack) begin
        lat  = i;
        data = regIf.reg_rd_data;
        break;
      end
    end
    checkOutput("rd_latency", lat, 1);
    @(negedge clk);
    checkOutput("rd_ack_width", {31'd0, regIf.reg_rd_ack}, 0);
    regIf.reg_rd_en = 1'b0;
  endtask

  task automatic applyStimulus(input int pulses);
    for (int i = 0; i < pulses; i++) begin
      @(negedge clk);
      statPktDone = 1'b1;
      @(negedge clk);
      statPktDone = 1'b0;
    end
  endtask

  initial begin
    int startBefore;
    regIf.reg_wr_addr = '0;
    regIf.reg_wr_data = '0;
    regIf.reg_wr_strb = '0;
    regIf.reg_wr_en   = 1'b0;
    regIf.reg_rd_addr = '0;
    regIf.reg_rd_en   = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_enable", {31'd0, cfgEnable}, 0);
    checkOutput("rst_start", {31'd0, cfgStart}, 0);
    checkOutput("rst_pkt_len", {16'd0, cfgPktLen}, 64);
    checkOutput("rst_gap", {16'd0, cfgPktGap}, 0);
    checkOutput("rst_seed", cfgSeed, 0);
    checkOutput("rst_rd_ack", {31'd0, regIf.reg_rd_ack}, 0);
    checkOutput("rst_wr_ack", {31'd0, regIf.reg_wr_ack}, 0);
    checkOutput("rst_rd_data", regIf.reg_rd_data, 0);
    checkOutput("wait_tied", {30'd0, regIf.reg_rd_wait, regIf.reg_wr_wait}, 0);
    rst = 1'b0;

    regRead(8'h08, 0, rdVal); checkOutput("rd_pkt_len_rst", rdVal, 32'd64);
    regRead(8'h18, 0, rdVal); checkOutput("rd_id", rdVal, 32'h4147_0100);
    regRead(8'h00, 0, rdVal); checkOutput("rd_ctrl_rst", rdVal, 32'd0);

    regWrite(8'h08, 32'h0000_0000, 4'hF, 0);
    regRead(8'h08, 0, rdVal); checkOutput("pkt_len_zero_clamp", rdVal, 32'd1);
    checkOutput("cfg_pkt_len_clamp", {16'd0, cfgPktLen}, 32'd1);
    regWrite(8'h08, 32'hABCD_1234, 4'b0001, 0);
    regRead(8'h08, 0, rdVal); checkOutput("pkt_len_strb", rdVal, 32'h0000_0034);

    startBefore = startCount;
    regWrite(8'h00, 32'h2, 4'hF, 0);
    repeat (2) @(negedge clk);
    checkOutput("start_no_enable", startCount - startBefore, 0);
    checkOutput("enable_still_off", {31'd0, cfgEnable}, 0);
    startBefore = startCount;
    regWrite(8'h00, 32'h3, 4'hF, 0);
    checkOutput("start_at_ack", {31'd0, startAtAck}, 1);
    repeat (2) @(negedge clk);
    checkOutput("start_single", startCount - startBefore, 1);
    checkOutput("enable_on", {31'd0, cfgEnable}, 1);
    regRead(8'h00, 0, rdVal); checkOutput("ctrl_readback", rdVal, 32'h1);

    fork
      regWrite(8'h0C, 32'h1234_5678, 4'hF, 0);
      begin
        logic [31:0] oldGap;
        regRead(8'h0C, 0, oldGap);
        checkOutput("concurrent_old_gap", oldGap, 32'd0);
      end
    join
    regRead(8'h0C, 0, rdVal); checkOutput("gap_readback", rdVal, 32'h0000_5678);
    checkOutput("cfg_gap", {16'd0, cfgPktGap}, 32'h5678);
    regWrite(8'h10, 32'hAABB_CCDD, 4'b1010, 0);
    regRead(8'h10, 0, rdVal); checkOutput("seed_strb", rdVal, 32'hAA00_CC00);
    checkOutput("cfg_seed", cfgSeed, 32'hAA00_CC00);

    regWrite(8'h1C, 32'hFFFF_FFFF, 4'hF, 0);
    regRead(8'h1C, 0, rdVal); checkOutput("unmapped_read", rdVal, 32'd0);

    applyStimulus(5);
    regRead(8'h14, 1, rdVal); checkOutput("count_read_5", rdVal, 32'd5);
    regRead(8'h14, 0, rdVal); checkOutput("count_after_clr", rdVal, 32'd1);

    statBusy = 1'b1;
    @(negedge clk);
    force dut.cntInst.count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cntInst.count_q;
    applyStimulus(3);
    regRead(8'h04, 0, rdVal); checkOutput("status_ovf", rdVal, 32'h3);
    regRead(8'h14, 0, rdVal); checkOutput("count_saturated", rdVal, 32'hFFFF_FFFF);
    regRead(8'h04, 0, rdVal); checkOutput("ovf_sticky", rdVal, 32'h3);
    regWrite(8'h00, 32'h4, 4'hF, 0);
    regRead(8'h04, 0, rdVal); checkOutput("ovf_cleared", rdVal, 32'h1);
    regRead(8'h14, 0, rdVal); checkOutput("count_cleared", rdVal, 32'd0);
    checkOutput("enable_off_by_clr", {31'd0, cfgEnable}, 0);
    regWrite(8'h00, 32'h4, 4'hF, 1);
    regRead(8'h14, 0, rdVal); checkOutput("clr_with_pulse", rdVal, 32'd1);

    regWrite(8'h00, 32'h1, 4'hF, 0);
    @(negedge clk);
    rst = 1'b1;
    regIf.reg_rd_addr = 8'h18;
    regIf.reg_rd_en   = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_rd_ack", {31'd0, regIf.reg_rd_ack}, 0);
    checkOutput("rst_mid_rd_data", regIf.reg_rd_data, 0);
    checkOutput("rst_mid_enable", {31'd0, cfgEnable}, 0);
    checkOutput("rst_mid_pkt_len", {16'd0, cfgPktLen}, 64);
    checkOutput("rst_mid_gap", {16'd0, cfgPktGap}, 0);
    checkOutput("rst_mid_seed", cfgSeed, 0);
    regIf.reg_rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    regRead(8'h04, 0, rdVal); checkOutput("rst_status", rdVal, 32'h1);
    regRead(8'h14, 0, rdVal); checkOutput("rst_count", rdVal, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_gen_regs.md
Name: axis_gen_regs

Overview:
- Control/status register file for the AXI-stream generator.
- Slave on the reg_rd_*/reg_wr_* register interface, which the AXI-lite register-interface read and write bridges drive.
- Presents configuration to the generator core and collects its status and packet-count events.
- Register map uses 32-bit words; register select is addr[ADDR_WIDTH-1:2].

Parameters:
- DATA_WIDTH, 32, register data width; only 32 is supported.
- ADDR_WIDTH, 8, register address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write byte-strobe width.
- CORE_ID, 32'h4147_0100, constant returned by the ID register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- reg_wr_addr  in  ADDR_WIDTH  write address.
- reg_wr_data  in  DATA_WIDTH  write data.
- reg_wr_strb  in  STRB_WIDTH  byte enables.
- reg_wr_en  in  1  write request; held until acked.
- reg_wr_wait  out  1  tied 0.
- reg_wr_ack  out  1  write completion pulse.
- reg_rd_addr  in  ADDR_WIDTH  read address.
- reg_rd_en  in  1  read request; held until acked.
- reg_rd_data  out  DATA_WIDTH  read data; valid while reg_rd_ack=1.
- reg_rd_wait  out  1  tied 0.
- reg_rd_ack  out  1  read completion pulse.
- cfg_enable  out  1  generator enable.
- cfg_start  out  1  one-cycle start pulse.
- cfg_pkt_len  out  16  packet length in beats; never 0.
- cfg_pkt_gap  out  16  idle cycles between packets.
- cfg_seed  out  32  pattern seed.
- stat_busy  in  1  generator active.
- stat_pkt_done  in  1  one-cycle pulse per packet sent.

Behaviour:
- Register map (byte offset):
  - 0x00 CTRL: bit0 ENABLE (RW); bit1 START (write-1 pulse, reads 0); bit2 CLR (write-1 clears PKT_COUNT and OVF, reads 0).
  - 0x04 STATUS (RO): bit0 = stat_busy, bit1 = OVF (sticky).
  - 0x08 PKT_LEN (RW, [15:0]): reset 64.
  - 0x0C GAP (RW, [15:0]): reset 0.
  - 0x10 SEED (RW, 32 bits): reset 0.
  - 0x14 PKT_COUNT (RO, clear-on-read): 32-bit saturating counter.
  - 0x18 ID (RO): CORE_ID.
  - Unused bits read 0.
  - Unmapped offsets read 0, writes are ignored, and both are still acked.
- Read handshake: the capture cycle is any cycle with reg_rd_en=1 and reg_rd_ack=0.
  - On the capture edge, reg_rd_data is registered and reg_rd_ack is set.
  - The next cycle reg_rd_ack returns to 0.
  - Latency: ack is 1 cycle after reg_rd_en rises.
  - reg_rd_en still high during the ack cycle never produces a second capture.
- Write handshake: same timing, using reg_wr_en and reg_wr_ack.
  - The register update commits on the capture edge.
  - Only bytes with reg_wr_strb set are updated.
  - CTRL START/CLR act only if byte 0 is strobed.
- PKT_LEN write resulting in 0 stores 1.
- cfg_start: asserted for exactly 1 cycle, the cycle after the START commit.
  - Requires ENABLE=1 after that commit. Writing 0x3 both enables and starts.
  - No pulse is generated when ENABLE=0.
- PKT_COUNT counting:
  - Increments on stat_pkt_done.
  - At 0xFFFF_FFFF it holds and sets OVF.
- PKT_COUNT clearing:
  - A read capture of 0x14 returns the pre-edge value and clears the counter on the same edge.
  - A simultaneous stat_pkt_done leaves the counter at 1; no event is lost.
  - A CLR write with a simultaneous stat_pkt_done likewise leaves the count at 1 and OVF at 0.
- Concurrent read and write: the interfaces operate independently. A read of the same address on the write commit edge returns the old value.
- Reset:
  - Outputs: cfg_enable=0, cfg_start=0, cfg_pkt_len=64, cfg_pkt_gap=0, cfg_seed=0, reg_rd_ack=0, reg_wr_ack=0, reg_rd_data=0.
  - Internal state: PKT_COUNT=0, OVF=0.
  - Reset mid-transaction drops any pending ack. The upstream bridge is reset on the same rst.

Decomposition:
- Package axis_gen_regs_pkg holds:
  - register offset constants;
  - CTRL/STATUS bit positions;
  - reset values (PKT_LEN_RST=64);
  - CORE_ID default.
- One sub-module: axis_gen_sat_cnt, a 32-bit saturating counter with inc, clr and overflow-flag. clr and inc in the same cycle gives count=1.

Test Plan:
- Reset, then read 0x08, 0x18 and 0x00 -> 64, 0x41470100 and 0. Each ack is exactly 1 cycle wide, 1 cycle after en rises.
- Write 0x08 = 0x0000_0000 with strb=4'hF -> readback 1. Write 0xABCD_1234 with strb=4'b0001 -> PKT_LEN=0x0034.
- Write CTRL=0x2 with ENABLE=0 -> no cfg_start. Write CTRL=0x3 -> cfg_enable=1 and a single cfg_start pulse; CTRL reads 0x1.
- Send 5 stat_pkt_done pulses, then read 0x14 with a pulse on the capture edge -> read returns 5; next read returns 1.
- Preload PKT_COUNT to 0xFFFF_FFFE via a backdoor force, then send 3 pulses -> count 0xFFFF_FFFF and STATUS bit1=1. Write CTRL=0x4 -> count 0 and OVF 0.
- Assert rst while reg_rd_en is high before ack -> no ack is issued and all outputs take their reset values next cycle.
